regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised successor to the pipeline register file, sitting between decode (reads) and writeback (writes) in the 5-stage core.
- Adds width/depth parameters and an optional hardwired zero register.
- Adds a hardware clear sequencer that initialises every entry after reset or on request. This replaces file-based init.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards without external tracking.
- Keeps two bypassed read ports and a debug/display read port.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
INIT_VAL, 0, value written to every entry by the clear sequencer
ZERO_REG, 0, 1 = entry 0 reads 0, ignores writes and scoreboard sets

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
clr_req  in  1  request full clear (sampled only when idle)
busy  out  1  clear sequencer running; core must stall
we  in  1  write enable (writeback)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
re1  in  1  read enable port 1
raddr1  in  ADDR_W  read address port 1
rdata1  out  DATA_W  read data port 1 (combinational)
re2  in  1  read enable port 2
raddr2  in  ADDR_W  read address port 2
rdata2  out  DATA_W  read data port 2 (combinational)
sb_set  in  1  mark sb_addr as having a write in flight (issue)
sb_addr  in  ADDR_W  destination being issued
pend1  out  1  raddr1 has an unresolved pending write
pend2  out  1  raddr2 has an unresolved pending write
dbg_sel  in  ADDR_W  debug read select
dbg_data  out  DATA_W  debug read data, no bypass

Behaviour:
- FSM states: INIT, IDLE. Counter clr_cnt is ADDR_W bits.
- rst low (async): state=INIT, clr_cnt=0, all pending bits=0, busy=1.
  - rdata1, rdata2, dbg_data, pend1 and pend2 are 0 while rst is low.
  - Array contents are not reset directly.
- INIT: each cycle, regs[clr_cnt] <= INIT_VAL and clr_cnt increments.
  - When clr_cnt == DEPTH-1, that entry is written, state goes to IDLE and clr_cnt goes to 0.
  - Clear takes exactly DEPTH cycles after reset release; busy drops on the following edge.
- INIT, other inputs:
  - we and sb_set are ignored.
  - clr_req is ignored; it does not restart the sequence.
  - Pending bits are held at 0.
  - All read outputs and pend outputs are 0.
- IDLE: clr_req=1 at an edge moves state to INIT with clr_cnt=0.
  - busy=1 from the next cycle.
  - Pending bits are cleared on that same edge.
  - A write presented in that same cycle is still performed.
- Write (IDLE): if we=1, regs[waddr] <= wdata at the edge.
  - If ZERO_REG=1 and waddr==0, the write is dropped.
- Read port k (combinational), first match wins:
  1. busy or rst low -> 0
  2. rek=0 -> 0
  3. ZERO_REG and raddrk==0 -> 0
  4. we=1 and waddr==raddrk -> wdata (bypass)
  5. otherwise -> regs[raddrk]
- dbg_data = regs[dbg_sel] in IDLE, 0 in INIT. No bypass; ZERO_REG still forces 0 for index 0.
- Scoreboard (IDLE):
  - we=1 clears pend[waddr].
  - sb_set=1 sets pend[sb_addr].
  - Same address in the same cycle: set wins, because a new producer replaces the retiring one.
  - ZERO_REG=1: sb_set on address 0 is ignored.
- pendk = rek & pend[raddrk] & ~(we & waddr==raddrk).
  - A writeback in the current cycle resolves the hazard, matching the bypass.
  - pendk is 0 when rek=0.
- Both read ports may use the same address; results are identical.
- Address widths are exact, so there is no out-of-range case.

Test Plan:
1. INIT_VAL=16'h00A5. Release rst. busy=1 for exactly 8 cycles, then 0. Every dbg_sel 0..7 returns 16'h00A5. rdata1=0 while busy, even with re1=1.
2. IDLE: write 16'h1234 to r3. Next cycle raddr1=3 gives 16'h1234. In the same write cycle, raddr2=3 gives 16'h1234 via bypass while dbg_sel=3 still shows the old 16'h00A5.
3. sb_set r5. Next cycle raddr1=5 gives pend1=1. Then we=1, waddr=5, wdata=16'hBEEF: in that cycle pend1=0 and rdata1=16'hBEEF. In the following cycle pend stays 0.
4. sb_set r2 and we to r2 in the same cycle. The write lands, and pend[2]=1 afterwards.
5. ZERO_REG=1: write 16'hFFFF to r0 and sb_set r0. Reading r0 gives 0 and pend1=0. dbg_sel=0 gives 0.
6. Write r4=16'h7777, assert clr_req, then pull rst low mid-clear.
   - After clr_req: busy=1 for 8 cycles and r4 returns to 16'h00A5.
   - rst low mid-clear: outputs go 0 immediately, and a full 8-cycle clear restarts after rst release.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with hardware clear sequencer, two bypassed read ports,
// a debug read port and a per-register pending-write scoreboard for RAW hazard detection.
module regfile_mp #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 3,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit              ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              pend1,
  output logic              pend2,
  input  logic [ADDR_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, IDLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              idle, wr_ok, sb_ok;
  assign busy  = (state_q == INIT);
  assign idle  = (state_q == IDLE) & rst;
  assign wr_ok = idle & we & ~(ZERO_REG && waddr == '0);
  assign sb_ok = sb_set & ~(ZERO_REG && sb_addr == '0);
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pend_d    = pend_q;
    if (state_q == INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      pend_d    = '0;
      state_d   = (clr_cnt_q == ADDR_W'(DEPTH - 1)) ? IDLE : INIT;
    end else if (clr_req) begin
      state_d   = INIT;
      clr_cnt_d = '0;
      pend_d    = '0;
    end else begin
      // set after clear so a new producer overrides the retiring one
      if (we) pend_d[waddr] = 1'b0;
      if (sb_ok) pend_d[sb_addr] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_q    <= pend_d;
    end
  end
  always_ff @(posedge clk) begin
    if (busy) regs_q[clr_cnt_q] <= INIT_VAL;
    else if (wr_ok) regs_q[waddr] <= wdata;
  end
  function automatic logic [DATA_W-1:0] rd(input logic re, input logic [ADDR_W-1:0] a);
    return (!idle || !re || (ZERO_REG && a == '0)) ? '0 :
           (we && waddr == a) ? wdata : regs_q[a];
  endfunction
  function automatic logic pd(input logic re, input logic [ADDR_W-1:0] a);
    return idle & re & pend_q[a] & ~(we && waddr == a);
  endfunction
  assign rdata1   = rd(re1, raddr1);
  assign rdata2   = rd(re2, raddr2);
  assign pend1    = pd(re1, raddr1);
  assign pend2    = pd(re2, raddr2);
  assign dbg_data = (!idle || (ZERO_REG && dbg_sel == '0)) ? '0 : regs_q[dbg_sel];
endmodule
